// File: rtl/sti_pkg.sv
// Shared helpers for the shared S-box pipeline: share-index arithmetic,
// table-select width and share packing offsets.
package sti_pkg;

    // Index of the share that sits 'i' positions around the share ring.
    function automatic int share_idx(input int i, input int shares);
        return i % shares;
    endfunction

    // Width of the truth-table select: one table per output bit.
    function automatic int sel_width(input int shares, input int nbits);
        return (shares * nbits > 1) ? $clog2(shares * nbits) : 1;
    endfunction

    // Bit offset of share k inside a packed share vector.
    function automatic int share_lsb(input int k, input int nbits);
        return k * nbits;
    endfunction

endpackage

// File: rtl/sti_sbox_pipe_if.sv
// Streaming data port of the shared S-box pipeline: input shares plus
// randomness in, masked output shares out.
interface sti_sbox_pipe_if #(
    parameter int SHARES = 4,
    parameter int NBITS  = 4
);
    // Both streams use valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; the sender holds its payload stable and keeps
    // valid high until that edge, and ready never depends on valid.
    logic                      in_valid;
    logic                      in_ready;
    logic [SHARES*NBITS-1:0]   in_shares;
    logic [SHARES*NBITS-1:0]   rnd;
    logic                      refresh_en;
    logic                      out_valid;
    logic                      out_ready;
    logic [SHARES*NBITS-1:0]   out_shares;

    modport master (
        output in_valid, in_shares, rnd, refresh_en, out_ready,
        input  in_ready, out_valid, out_shares
    );

    modport slave (
        input  in_valid, in_shares, rnd, refresh_en, out_ready,
        output in_ready, out_valid, out_shares
    );
endinterface

// File: rtl/sti_lut_bank.sv
// Bank of programmable 1-bit truth tables, one per output share bit, read
// combinationally from the two neighbouring input shares only.
module sti_lut_bank
    import sti_pkg::*;
#(
    parameter int SHARES = 4,
    parameter int NBITS  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [sel_width(SHARES, NBITS)-1:0]  sel,
    input  logic [2*NBITS-1:0]                   addr,
    input  logic                                 wdata,
    input  logic [SHARES*NBITS-1:0]              x,
    output logic [SHARES*NBITS-1:0]              y
);
    localparam int NT    = SHARES * NBITS;
    localparam int DEPTH = 2 ** (2 * NBITS);

    logic [NT-1:0][DEPTH-1:0] tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl <= '0;
        end else if (we && (int'(sel) < NT)) begin
            tbl[sel][addr] <= wdata;
        end
    end

    // Output share i never sees input share i, which keeps the bank non-complete.
    for (genvar t = 0; t < NT; t++) begin : g_rd
        localparam int I  = t / NBITS;
        localparam int HI = share_lsb(share_idx(I + 1, SHARES), NBITS);
        localparam int LO = share_lsb(share_idx(I + 2, SHARES), NBITS);
        logic [2*NBITS-1:0] idx;
        assign idx  = {x[HI +: NBITS], x[LO +: NBITS]};
        assign y[t] = tbl[t][idx];
    end

endmodule

// File: rtl/sti_sbox_pipe.sv
// Two-stage threshold-implementation S-box: S1 holds the accepted shares,
// S2 holds the table outputs, optionally re-masked with fresh randomness.
module sti_sbox_pipe
    import sti_pkg::*;
#(
    parameter int SHARES = 4,
    parameter int NBITS  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    sti_sbox_pipe_if.slave                       bus,
    input  logic                                 cfg_we,
    input  logic [sel_width(SHARES, NBITS)-1:0]  cfg_sel,
    input  logic [2*NBITS-1:0]                   cfg_addr,
    input  logic                                 cfg_wdata,
    output logic                                 busy,
    output logic                                 cfg_err,
    input  logic                                 cfg_err_clr
);
    localparam int NT = SHARES * NBITS;

    logic          s1_valid;
    logic          s1_refresh;
    logic [NT-1:0] s1_shares;
    logic [NT-1:0] s1_rnd;
    logic          s2_valid;
    logic [NT-1:0] s2_shares;
    logic [NT-1:0] lut_y;
    logic [NT-1:0] mask;
    logic          s2_free;
    logic          accept;
    logic          tbl_we;

    assign s2_free      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = s1_valid || s2_valid;
    assign tbl_we       = cfg_we && !busy;

    assign bus.out_valid  = s2_valid;
    assign bus.out_shares = s2_shares;

    // Each random share is used by two adjacent masks, so the masks cancel in the share XOR.
    for (genvar i = 0; i < SHARES; i++) begin : g_mask
        localparam int NX = share_lsb(share_idx(i + 1, SHARES), NBITS);
        assign mask[i*NBITS +: NBITS] = s1_rnd[i*NBITS +: NBITS] ^ s1_rnd[NX +: NBITS];
    end

    sti_lut_bank #(
        .SHARES (SHARES),
        .NBITS  (NBITS)
    ) u_lut_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (tbl_we),
        .sel   (cfg_sel),
        .addr  (cfg_addr),
        .wdata (cfg_wdata),
        .x     (s1_shares),
        .y     (lut_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_refresh <= 1'b0;
            s1_shares  <= '0;
            s1_rnd     <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_shares  <= bus.in_shares;
                s1_rnd     <= bus.rnd;
                s1_refresh <= bus.refresh_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_shares <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_shares <= s1_refresh ? (lut_y ^ mask) : lut_y;
            end
        end
    end

    // A rejected write in the same cycle as a clear must still be reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (cfg_we && busy) begin
            cfg_err <= 1'b1;
        end else if (cfg_err_clr) begin
            cfg_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sti_sbox_pipe.sv
// Directed bench for sti_sbox_pipe with SHARES=4, NBITS=4.
module tb_sti_sbox_pipe;
    import sti_pkg::*;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_sel;
    logic [7:0]  cfg_addr;
    logic        cfg_wdata;
    logic        busy;
    logic        cfg_err;
    logic        cfg_err_clr;

    int checks;
    int errors;
    logic [15:0] exp_q[$];

    sti_sbox_pipe_if #(.SHARES(4), .NBITS(4)) bus ();

    sti_sbox_pipe #(.SHARES(4), .NBITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .cfg_err_clr (cfg_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] fold(input logic [15:0] s);
        return s[3:0] ^ s[7:4] ^ s[11:8] ^ s[15:12];
    endfunction

    // Drivers: all inputs change 1 time unit after a rising edge.
    task automatic do_write(input logic [3:0] sel, input logic [7:0] addr, input logic d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] x, input logic ren, input logic [15:0] r);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_shares = x; bus.refresh_en = ren; bus.rnd = r;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 20 cycles", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(output logic [15:0] y, output logic ok);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        y  = bus.out_shares;
        ok = bus.out_valid;
        if (ok) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_shares = '0; bus.rnd = '0; bus.refresh_en = 1'b0;
        bus.out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = 1'b0; cfg_err_clr = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_during: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     bus.out_valid, busy, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            cfg_err !== 1'b0 || bus.out_shares !== 16'h0000) begin
            errors++;
            $display("FAIL reset_after: out_valid=%b busy=%b in_ready=%b cfg_err=%b out=%h, required 0 0 1 0 0000",
                     bus.out_valid, busy, bus.in_ready, cfg_err, bus.out_shares);
        end
    endtask

    task automatic test_latency_zero_tables();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_shares = 16'h1234; bus.refresh_en = 1'b0; bus.rnd = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b one edge after input, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_shares !== 16'h0000) begin
            errors++;
            $display("FAIL latency_two: out_valid=%b out=%h, required 1 0000", bus.out_valid, bus.out_shares);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: out_valid=%b busy=%b, required 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_single_entry();
        logic [15:0] y;
        logic ok;
        do_write(4'd0, 8'h5A, 1'b1);
        send(16'h0A50, 1'b0, '0);
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0001) begin
            errors++;
            $display("FAIL single_entry: valid=%b out=%h, required 1 0001", ok, y);
        end
        // Share 0 input changes; output share 0 must not follow it.
        send(16'h0A5F, 1'b0, '0);
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0001) begin
            errors++;
            $display("FAIL non_complete: valid=%b out=%h, required 1 0001", ok, y);
        end
    endtask

    task automatic test_same_cycle_cfg();
        logic [15:0] y;
        logic ok;
        cfg_we = 1'b1; cfg_sel = 4'd5; cfg_addr = 8'hC3; cfg_wdata = 1'b1;
        bus.in_valid = 1'b1; bus.in_shares = 16'h3C00; bus.refresh_en = 1'b0; bus.rnd = '0;
        @(posedge clk); #1;
        cfg_we = 1'b0; bus.in_valid = 1'b0;
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0020) begin
            errors++;
            $display("FAIL same_cycle_cfg: valid=%b out=%h, required 1 0020", ok, y);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        logic fire_in;
        logic fire_out;
        logic [15:0] e;
        exp_q.delete();
        bus.out_ready = 1'b0;
        bus.refresh_en = 1'b0; bus.rnd = '0;
        bus.in_valid = 1'b1; bus.in_shares = 16'h0A50;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept1: in_ready=%b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        exp_q.push_back(16'h0001);
        bus.in_shares = 16'h3C00;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept2: in_ready=%b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        exp_q.push_back(16'h0020);
        bus.in_shares = 16'h0000;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_block3: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_shares !== 16'h0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b out=%h busy=%b, required 0 1 0001 1",
                     bus.in_ready, bus.out_valid, bus.out_shares, busy);
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid;
            if (fire_out) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (bus.out_shares !== e) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: out=%h, required %h", got, bus.out_shares, e);
                end
                got++;
            end
            @(posedge clk); #1;
            if (fire_in) begin
                exp_q.push_back(16'h0000);
                bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (got != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: received %0d left %0d, required 3 received 0 left", got, exp_q.size());
        end
    endtask

    task automatic test_refresh();
        logic [15:0] exp_off;
        logic [15:0] y_off;
        logic [15:0] y_on;
        logic ok;
        logic b;
        logic [7:0] adr [4];
        // Table addresses used by input 0x1234 for output shares 0..3.
        adr[0] = 8'h32; adr[1] = 8'h21; adr[2] = 8'h14; adr[3] = 8'h43;
        exp_off = '0;
        for (int t = 0; t < 16; t++) begin
            b = 1'($urandom_range(1, 0));
            do_write(4'(t), adr[t/4], b);
            exp_off[t] = b;
        end
        send(16'h1234, 1'b0, '0);
        recv(y_off, ok);
        checks++;
        if (!ok || y_off !== exp_off) begin
            errors++;
            $display("FAIL refresh_off: valid=%b out=%h, required 1 %h", ok, y_off, exp_off);
        end
        send(16'h1234, 1'b1, 16'hA5C3);
        recv(y_on, ok);
        checks++;
        if (!ok || y_on !== (exp_off ^ 16'h9F9F)) begin
            errors++;
            $display("FAIL refresh_on: valid=%b out=%h, required 1 %h", ok, y_on, exp_off ^ 16'h9F9F);
        end
        checks++;
        if (fold(y_on) !== fold(exp_off)) begin
            errors++;
            $display("FAIL refresh_xor: share xor=%h, required %h", fold(y_on), fold(exp_off));
        end
    endtask

    task automatic test_cfg_err();
        logic [15:0] y;
        logic ok;
        bus.out_ready = 1'b0;
        send(16'h0A50, 1'b0, '0);
        cfg_we = 1'b1; cfg_sel = 4'd0; cfg_addr = 8'h5A; cfg_wdata = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++; $display("FAIL cfg_err_set: cfg_err=%b, required 1", cfg_err);
        end
        cfg_we = 1'b1; cfg_err_clr = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_err_clr = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++; $display("FAIL cfg_err_clr_race: cfg_err=%b, required 1", cfg_err);
        end
        bus.out_ready = 1'b1;
        recv(y, ok);
        send(16'h0A50, 1'b0, '0);
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0001) begin
            errors++; $display("FAIL cfg_err_entry: valid=%b out=%h, required 1 0001", ok, y);
        end
        cfg_err_clr = 1'b1;
        @(posedge clk); #1;
        cfg_err_clr = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++; $display("FAIL cfg_err_clear: cfg_err=%b, required 0", cfg_err);
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] y;
        logic ok;
        logic seen;
        bus.out_ready = 1'b0;
        send(16'h0A50, 1'b0, '0);
        send(16'h3C00, 1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_shares !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b busy=%b in_ready=%b out=%h, required 0 0 1 0000",
                     bus.out_valid, busy, bus.in_ready, bus.out_shares);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_no_output: out_valid seen=%b, required 0", seen);
        end
        send(16'h0A50, 1'b0, '0);
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0000) begin
            errors++; $display("FAIL rst_tbl0_zero: valid=%b out=%h, required 1 0000", ok, y);
        end
        send(16'h3C00, 1'b0, '0);
        recv(y, ok);
        checks++;
        if (!ok || y !== 16'h0000) begin
            errors++; $display("FAIL rst_tbl5_zero: valid=%b out=%h, required 1 0000", ok, y);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency_zero_tables();
        test_single_entry();
        test_same_cycle_cfg();
        test_back_to_back();
        test_refresh();
        test_cfg_err();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sti_sbox_pipe.md
STI_SBOX_PIPE -- requirements
Module: sti_sbox_pipe

Interface
REQ-001 SHALL have parameter SHARES, default 4, number of Boolean shares (legal 3..4).
REQ-002 SHALL have parameter NBITS, default 4, S-box width in bits per share.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  input shares present.
REQ-006 SHALL have port in_ready  output  1  input accepted when high with in_valid.
REQ-007 SHALL have port in_shares  input  SHARES*NBITS  share k at bits [k*NBITS +: NBITS].
REQ-008 SHALL have port rnd  input  SHARES*NBITS  fresh randomness, sampled with each accepted input.
REQ-009 SHALL have port refresh_en  input  1  enables output re-masking, sampled with each accepted input.
REQ-010 SHALL have port out_valid  output  1  output shares present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_shares  output  SHARES*NBITS  same packing as in_shares.
REQ-013 SHALL have port cfg_we  input  1  truth-table write strobe.
REQ-014 SHALL have port cfg_sel  input  clog2(SHARES*NBITS)  table select = share*NBITS+bit.
REQ-015 SHALL have port cfg_addr  input  2*NBITS  table entry index.
REQ-016 SHALL have port cfg_wdata  input  1  entry value.
REQ-017 SHALL have port busy  output  1  any pipeline stage valid.
REQ-018 SHALL have port cfg_err  output  1  sticky: write attempted while busy.
REQ-019 SHALL have port cfg_err_clr  input  1  clears cfg_err.

Function
REQ-020 SHALL hold SHARES*NBITS programmable truth tables, each 2^(2*NBITS) x 1 bit, all zero after reset.
REQ-021 Output share i bit b SHALL equal table(i*NBITS+b)[{x[(i+1)%SHARES], x[(i+2)%SHARES]}], upper NBITS = share (i+1)%SHARES; share i never used (non-completeness).
REQ-022 Pipeline SHALL be two stages: S1 registers in_shares/rnd/refresh_en on acceptance; S2 registers table outputs, XORed with refresh mask when enabled.
REQ-023 Refresh mask for share i SHALL be r[i] ^ r[(i+1)%SHARES]; XOR of all output shares unchanged by refresh.
REQ-024 Latency SHALL be exactly 2 cycles from accepting edge to out_valid with no backpressure; throughput one per cycle.
REQ-025 out_shares SHALL hold stable while out_valid && !out_ready.
REQ-026 in_ready SHALL equal !S1_valid || (!S2_valid || out_ready) (S1 advances when S2 free or draining); no combinational in_valid->in_ready path.
REQ-027 Simultaneous output drain and input accept SHALL lose no data; two items storable under full backpressure.
REQ-028 cfg_we with busy==0 SHALL write entry next edge; with busy==1 SHALL be ignored and set cfg_err.
REQ-029 cfg_err_clr and a failing cfg_we in the same cycle SHALL leave cfg_err=1.
REQ-030 cfg_we with in_valid in same cycle while idle SHALL write table; accepted input uses new value.

Reset
REQ-031 rst SHALL asynchronously clear S1/S2 valid, out_shares, all tables, cfg_err; out_valid=0, busy=0, in_ready=1 during and after reset.
REQ-032 Reset mid-operation SHALL discard in-flight items; no output after deassertion until new input.

Structure
REQ-033 Share-index helper (mod SHARES), table-select width and packing macros SHALL live in shared package sti_pkg.
REQ-034 One sub-module sti_lut_bank (table storage, write port, combinational read) SHALL be instantiated; the rest is the pipeline/handshake.

Verification
REQ-035 Reset, in_shares=0x1234, refresh off, out_ready=1 -> out_shares=0x0000, out_valid exactly 2 cycles later.
REQ-036 Write table0 addr 0x5A=1; input share1=5, share2=A, others 0 -> out share0 bit0=1, all other bits 0.
REQ-037 out_ready=0, drive 3 inputs -> first two accepted, in_ready=0 on third; release -> 3 outputs in order, none lost.
REQ-038 Random tables, refresh_en=1, rnd=0xA5C3 -> XOR of out shares equals refresh-off result for same input.
REQ-039 cfg_we while busy=1 -> cfg_err=1, table entry unchanged; cfg_err_clr -> cfg_err=0.
REQ-040 rst asserted with 2 items in flight -> out_valid=0 immediately, busy=0, tables zero.
